ib_lut_page_loader: RTL and testbench
=====================================

IB_LUT_PAGE_LOADER -- requirements
Module: ib_lut_page_loader

Interface
REQ-001 SHALL have parameter ENTRY_ADDR, default 6, meaning the page-address width including the multi-frame offset MSB.
REQ-002 SHALL have parameter LUT_PORT_SIZE, default 3, meaning the LUT entry width per bank.
REQ-003 SHALL have parameter BANK_NUM, default 2, meaning the number of banks per write word.
REQ-004 SHALL have parameter PAGE_NUM, default 32, meaning the pages per frame; it equals 2**(ENTRY_ADDR-1).
REQ-005 SHALL have port write_clk, input, 1 bit: the single clock. All logic is rising-edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port load_start, input, 1 bit: one-cycle request to load one frame's LUT.
REQ-008 SHALL have port load_frame, input, 1 bit: frame offset; sampled with load_start.
REQ-009 SHALL have port load_abort, input, 1 bit: synchronous cancel of the current load.
REQ-010 SHALL have port src_data, input, LUT_PORT_SIZE*BANK_NUM bits: {bank0, bank1} LUT word.
REQ-011 SHALL have port src_valid, input, 1 bit: src_data is valid.
REQ-012 SHALL have port src_ready, output, 1 bit: the loader accepts a beat.
REQ-013 SHALL have port page_addr_ram, output, ENTRY_ADDR bits: {frame offset, page index} to the IB-CNU RAMs.
REQ-014 SHALL have port ram_write_data, output, LUT_PORT_SIZE*BANK_NUM bits: the registered copy of the accepted src_data.
REQ-015 SHALL have port ib_ram_we, output, 1 bit: write enable to all func RAMs of the stage.
REQ-016 SHALL have port busy, output, 1 bit: high in the LOAD state.
REQ-017 SHALL have port load_done, output, 1 bit: one-cycle pulse after the last page is written.

Function
REQ-018 SHALL implement the states IDLE, LOAD and FLUSH.
REQ-019 IDLE->LOAD SHALL occur on load_start; the loader latches load_frame and clears the page counter to 0.
REQ-020 SHALL assert src_ready exactly when the state is LOAD; a beat is accepted when src_valid && src_ready.
REQ-021 For a beat accepted in cycle N, page_addr_ram, ram_write_data and ib_ram_we=1 SHALL all be registered and visible in cycle N+1; ib_ram_we SHALL be 0 in every other cycle.
REQ-022 page_addr_ram SHALL be {latched frame, page counter value at acceptance}; the counter increments by 1 per accepted beat.
REQ-023 When the beat with page PAGE_NUM-1 is accepted, the state SHALL go LOAD->FLUSH; the counter wraps to 0 and does not exceed PAGE_NUM-1.
REQ-024 FLUSH SHALL last one cycle, during which the last write is visible; then FLUSH->IDLE and load_done=1 for exactly that FLUSH cycle.
REQ-025 src_valid gaps SHALL stall the counter without writes; there is no timeout.
REQ-026 load_start SHALL be ignored while in LOAD or FLUSH.
REQ-027 load_abort in LOAD SHALL force IDLE next cycle with no load_done; a beat presented in the same cycle is not accepted (abort dominates, src_ready forced to 0).
REQ-028 load_abort in IDLE or FLUSH SHALL have no effect.
REQ-029 src_valid while in IDLE SHALL be ignored (no write).

Reset
REQ-030 rstn=0 SHALL asynchronously force IDLE, counter=0, frame=0, page_addr_ram=0, ram_write_data=0, ib_ram_we=0, src_ready=0, busy=0 and load_done=0, including in the middle of a load.
REQ-031 After rstn deasserts, the loader SHALL require a new load_start; a partial load is never resumed.

Configuration
REQ-032 When IB_LOADER_ERR_EN is defined, the loader SHALL add an output load_err (1 bit, reset 0, sticky until the next reset) that is set by load_start in LOAD/FLUSH or by src_valid in IDLE.
REQ-033 When IB_LOADER_ERR_EN is undefined, the load_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 The state encoding (IDLE=0, LOAD=1, FLUSH=2) and the PAGE_NUM-derived constants SHALL reside in the shared package / define.vh.
REQ-035 SHALL be a single module with no sub-modules; the page counter is inline.

Verification
REQ-036 Full load: load_frame=1, 32 back-to-back beats with data=6'h00..6'h1F -> we high 32 cycles, page_addr_ram 6'h20..6'h3F, data matches, load_done on the cycle after the last write.
REQ-037 Stall: a 3-cycle src_valid gap after page 5 -> no we during the gap, page 6 follows, 32 writes in total.
REQ-038 Abort: load_abort together with the page-10 beat -> the page-10 beat is not written, IDLE, no load_done, busy=0 next cycle.
REQ-039 Reset: rstn low at page 17 -> all outputs 0 immediately; a new load with frame 0 starts at page_addr_ram=6'h00.
REQ-040 Ignored start: load_start during LOAD -> frame and counter unchanged; with IB_LOADER_ERR_EN, load_err=1 and it stays set.
REQ-041 IDLE noise: src_valid=1 for 4 cycles in IDLE -> ib_ram_we=0 and src_ready=0 throughout.

Source files
------------

// File: rtl/ib_lut_page_loader_pkg.sv
// Shared definitions for the IB LUT page loader: FSM state encoding and page-count constants.
package ib_lut_page_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } loader_state_t;

  localparam int DEF_ENTRY_ADDR    = 6;
  localparam int DEF_LUT_PORT_SIZE = 3;
  localparam int DEF_BANK_NUM      = 2;

  // One frame holds half the page-address space; the address MSB selects the frame.
  function automatic int pages_per_frame(input int entry_addr);
    return 1 << (entry_addr - 1);
  endfunction

  localparam int DEF_PAGE_NUM = pages_per_frame(DEF_ENTRY_ADDR);

endpackage

// File: rtl/ib_lut_page_loader.sv
// Streams one frame of LUT words into the IB-CNU RAMs, one page per accepted beat.
// Optional sticky protocol-error flag load_err is built when IB_LOADER_ERR_EN is defined.
module ib_lut_page_loader
  import ib_lut_page_loader_pkg::*;
#(
  parameter int ENTRY_ADDR    = DEF_ENTRY_ADDR,
  parameter int LUT_PORT_SIZE = DEF_LUT_PORT_SIZE,
  parameter int BANK_NUM      = DEF_BANK_NUM,
  parameter int PAGE_NUM      = DEF_PAGE_NUM
) (
  input  logic                              write_clk,
  input  logic                              rstn,
  input  logic                              load_start,
  input  logic                              load_frame,
  input  logic                              load_abort,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
  input  logic                              src_valid,
  output logic                              src_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
  output logic                              ib_ram_we,
  output logic [1:0]                        dbg_state,
  output logic                              busy,
  output logic                              load_done
`ifdef IB_LOADER_ERR_EN
  ,
  output logic                              load_err
`endif
);

  localparam int CNT_W = ENTRY_ADDR - 1;
  localparam logic [CNT_W-1:0] LAST_PAGE = CNT_W'(PAGE_NUM - 1);

  // Handshake: a beat transfers in any cycle where src_valid && src_ready.
  // src_ready is high only in LOAD, and an abort in the same cycle withdraws it.

  loader_state_t    state;
  logic [CNT_W-1:0] page_cnt;
  logic             frame;
  logic             accept;

  assign src_ready = (state == ST_LOAD) && !load_abort;
  assign accept    = src_ready && src_valid;
  assign busy      = (state == ST_LOAD);
  // FLUSH is exactly the cycle in which the final page write is on the RAM port.
  assign load_done = (state == ST_FLUSH);
  assign dbg_state = state;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      page_cnt       <= '0;
      frame          <= 1'b0;
      page_addr_ram  <= '0;
      ram_write_data <= '0;
      ib_ram_we      <= 1'b0;
    end else begin
      ib_ram_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state    <= ST_LOAD;
            frame    <= load_frame;
            page_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (load_abort) begin
            state <= ST_IDLE;
          end else if (accept) begin
            ib_ram_we      <= 1'b1;
            page_addr_ram  <= {frame, page_cnt};
            ram_write_data <= src_data;
            if (page_cnt == LAST_PAGE) begin
              page_cnt <= '0;
              state    <= ST_FLUSH;
            end else begin
              page_cnt <= page_cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef IB_LOADER_ERR_EN
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      load_err <= 1'b0;
    end else if ((load_start && state != ST_IDLE) || (src_valid && state == ST_IDLE)) begin
      load_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ib_lut_page_loader.sv
// Randomized scoreboard bench for ib_lut_page_loader; covers load_err when IB_LOADER_ERR_EN is defined.
module tb_ib_lut_page_loader;

  localparam int EA = 6;
  localparam int DW = 6;
  localparam int PN = 32;
  localparam int EW = 1 + EA + DW;

  logic          write_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load_start = 1'b0;
  logic          load_frame = 1'b0;
  logic          load_abort = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [EA-1:0] page_addr_ram;
  logic [DW-1:0] ram_write_data;
  logic          ib_ram_we;
  logic [1:0]    dbg_state;
  logic          busy;
  logic          load_done;
`ifdef IB_LOADER_ERR_EN
  logic          load_err;
`endif

  ib_lut_page_loader dut (
    .write_clk      (write_clk),
    .rstn           (rstn),
    .load_start     (load_start),
    .load_frame     (load_frame),
    .load_abort     (load_abort),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .page_addr_ram  (page_addr_ram),
    .ram_write_data (ram_write_data),
    .ib_ram_we      (ib_ram_we),
    .dbg_state      (dbg_state),
    .busy           (busy),
    .load_done      (load_done)
`ifdef IB_LOADER_ERR_EN
    ,
    .load_err       (load_err)
`endif
  );

  always #5 write_clk = ~write_clk;

  int errors = 0;
  int checks = 0;

  // Expected write stream: {is_final_page, page address, data}.
  logic [EW-1:0] exp_q[$];

  // Reference model: a load is "active" while pages are still owed,
  // "flushing" for the one cycle after the final page is accepted.
  bit m_active = 0;
  bit m_flush  = 0;
  bit m_frame  = 0;
  int m_page   = 0;
  bit m_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write seen on the RAM port must match the next expected entry.
  always @(negedge write_clk) begin
    logic [EW-1:0] e;
    if (ib_ram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with empty queue at %0t",
                 page_addr_ram, ram_write_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(page_addr_ram), 32'(e[EA+DW-1:DW]));
        check("write_data", 32'(ram_write_data), 32'(e[DW-1:0]));
        check("done_with_write", 32'(load_done), 32'(e[EW-1]));
      end
    end else begin
      check("done_without_write", 32'(load_done), 32'(0));
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic start, input logic frame, input logic abort,
                       input logic valid, input logic [DW-1:0] data);
    bit last;
    load_start = start;
    load_frame = frame;
    load_abort = abort;
    src_valid  = valid;
    src_data   = data;
    #1;
    check("src_ready", 32'(src_ready), 32'(m_active && !abort));
    check("busy", 32'(busy), 32'(m_active));
`ifdef IB_LOADER_ERR_EN
    check("load_err", 32'(load_err), 32'(m_err));
`endif
    if (m_active) begin
      if (start) m_err = 1;
      if (abort) begin
        m_active = 0;
      end else if (valid) begin
        last = (m_page == PN - 1);
        exp_q.push_back({last, m_frame, 5'(m_page), data});
        if (last) begin
          m_active = 0;
          m_flush  = 1;
        end else begin
          m_page++;
        end
      end
    end else if (m_flush) begin
      if (start) m_err = 1;
      m_flush = 0;
    end else begin
      if (valid) m_err = 1;
      if (start) begin
        m_active = 1;
        m_frame  = frame;
        m_page   = 0;
      end
    end
    @(posedge write_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(ib_ram_we), 32'(0));
    check({tag, "_addr"}, 32'(page_addr_ram), 32'(0));
    check({tag, "_data"}, 32'(ram_write_data), 32'(0));
    check({tag, "_ready"}, 32'(src_ready), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(load_done), 32'(0));
`ifdef IB_LOADER_ERR_EN
    check({tag, "_err"}, 32'(load_err), 32'(0));
`endif
  endtask

  initial begin
    // Clock/reset
    repeat (2) @(posedge write_clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge write_clk);
    #1;

    // Noise in IDLE must not write
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'($urandom));
    idle(2);

    // Full back-to-back load into frame 1
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < PN; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'(i));
    idle(3);

    // 3-cycle gap after page 5, with a second start ignored mid-load
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < PN; i++) begin
      if (i == 6) begin
        for (int g = 0; g < 3; g++) cycle(g == 1, 1'b1, 1'b0, 1'b0, '0);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'($urandom));
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(2);

    // Abort together with the page-10 beat
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'($urandom));
    cycle(1'b0, 1'b0, 1'b1, 1'b1, DW'($urandom));
    idle(3);

    // Reset in the middle of a load, after page 16 is written
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'($urandom));
    @(negedge write_clk);
    #1;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    check("queue_at_reset", 32'(exp_q.size()), 32'(0));
    m_active = 0;
    m_flush  = 0;
    m_page   = 0;
    m_frame  = 0;
    m_err    = 0;
    @(posedge write_clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'($urandom));
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < PN; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'($urandom));
    idle(2);

    // Randomized loads with gaps, stray starts and occasional aborts
    for (int r = 0; r < 8; r++) begin
      cycle(1'b1, 1'($urandom), 1'b0, 1'($urandom), DW'($urandom));
      for (int c = 0; c < 200 && m_active; c++) begin
        cycle($urandom_range(0, 20) == 0, 1'($urandom), $urandom_range(0, 80) == 0,
              $urandom_range(0, 3) != 0, DW'($urandom));
      end
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
      idle($urandom_range(1, 3));
    end

    idle(3);
    check("pending_writes", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
